// File: rtl/encoder_config_sequencer_if.sv
// Request, host debug-bus and encoder debug-bus bundle for encoder_config_sequencer.
// The timeout strobe exists only when SEQ_TIMEOUT_EN is defined.
interface encoder_config_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_standard;
  logic        req_ready;
  logic        newframe;
  logic [15:0] host_addr;
  logic [7:0]  host_write_data;
  logic        host_write_enable;
  logic        host_stall;
  logic [15:0] dbus_addr;
  logic [7:0]  dbus_write_data;
  logic        dbus_write_enable;
  logic [1:0]  video_standard;
  logic        busy;
  logic        done;
`ifdef SEQ_TIMEOUT_EN
  logic        timeout;

  modport master (
    output req_valid, req_standard, newframe, host_addr, host_write_data, host_write_enable,
    input  req_ready, host_stall, dbus_addr, dbus_write_data, dbus_write_enable,
    input  video_standard, busy, done, timeout
  );

  modport slave (
    input  req_valid, req_standard, newframe, host_addr, host_write_data, host_write_enable,
    output req_ready, host_stall, dbus_addr, dbus_write_data, dbus_write_enable,
    output video_standard, busy, done, timeout
  );
`else
  modport master (
    output req_valid, req_standard, newframe, host_addr, host_write_data, host_write_enable,
    input  req_ready, host_stall, dbus_addr, dbus_write_data, dbus_write_enable,
    input  video_standard, busy, done
  );

  modport slave (
    input  req_valid, req_standard, newframe, host_addr, host_write_data, host_write_enable,
    output req_ready, host_stall, dbus_addr, dbus_write_data, dbus_write_enable,
    output video_standard, busy, done
  );
`endif
endinterface

// File: rtl/encoder_config_sequencer.sv
// Reloads encoder scaler/level/delay/chroma registers at a frame start, then switches video_standard;
// host writes pass through registered (1 cycle) except in WRITE/COMMIT where host_stall holds them. Option: SEQ_TIMEOUT_EN.
module encoder_config_sequencer #(
  parameter int unsigned NUM_ENTRIES    = 8
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  encoder_config_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WRITE      = 2'd2,
    COMMIT     = 2'd3
  } state_e;

  localparam logic [1:0] STD_PAL     = 2'd0;
  localparam logic [1:0] STD_INVALID = 2'd3;
  localparam logic [2:0] LAST_IDX    = 3'(NUM_ENTRIES - 1);

  // Columns: Y scaler, U scaler, V scaler, black level, luma delay, U delay, V delay, chroma ctrl.
  // Row 3 is never selected because the invalid standard is discarded at request time.
  localparam logic [7:0] CONFIG_DEFAULTS [4][8] = '{
    '{8'h9A, 8'h44, 8'h60, 8'h10, 8'h02, 8'h04, 8'h04, 8'h01},  // PAL
    '{8'h94, 8'h4B, 8'h6A, 8'h18, 8'h03, 8'h05, 8'h05, 8'h03},  // NTSC
    '{8'h9A, 8'h3A, 8'h52, 8'h10, 8'h02, 8'h06, 8'h06, 8'h05},  // SECAM
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  function automatic logic [15:0] table_addr(input logic [1:0] std, input logic [2:0] idx);
    logic [15:0] a;
    case (idx)
      3'd0:    a = 16'h0200 + {14'd0, std};
      3'd1:    a = 16'h0204 + {14'd0, std};
      3'd2:    a = 16'h0208 + {14'd0, std};
      3'd3:    a = 16'h0009;
      3'd4:    a = 16'h0000;
      3'd5:    a = 16'h000C;
      3'd6:    a = 16'h000D;
      default: a = 16'h0006;
    endcase
    return a;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  std_q, std_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  vstd_q, vstd_d;
  logic        done_q, done_d;
  logic [15:0] dbus_addr_q, dbus_addr_d;
  logic [7:0]  dbus_data_q, dbus_data_d;
  logic        dbus_we_q, dbus_we_d;
  logic        frame_go;

`ifdef SEQ_TIMEOUT_EN
  logic [19:0] cnt_q, cnt_d;
  logic        expired;

  always_comb begin
    cnt_d   = (state_q == WAIT_FRAME) ? cnt_q + 20'd1 : 20'd0;
    expired = (state_q == WAIT_FRAME) && (cnt_q == 20'(TIMEOUT_CYCLES - 1));
    // A real frame start in the expiry cycle wins, so no timeout is reported then.
    frame_go    = bus.newframe || expired;
    bus.timeout = expired && !bus.newframe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 20'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    frame_go = bus.newframe;
  end
`endif

  always_comb begin
    state_d     = state_q;
    std_d       = std_q;
    idx_d       = idx_q;
    vstd_d      = vstd_q;
    done_d      = 1'b0;
    dbus_addr_d = bus.host_addr;
    dbus_data_d = bus.host_write_data;
    dbus_we_d   = bus.host_write_enable;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_standard != STD_INVALID) begin
          std_d   = bus.req_standard;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_go) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        dbus_addr_d = table_addr(std_q, idx_q);
        dbus_data_d = CONFIG_DEFAULTS[std_q][idx_q];
        dbus_we_d   = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 3'd0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        // COMMIT: the host is still stalled, so the bus idles with its last address/data.
        dbus_addr_d = dbus_addr_q;
        dbus_data_d = dbus_data_q;
        dbus_we_d   = 1'b0;
        vstd_d      = std_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      std_q       <= STD_PAL;
      idx_q       <= 3'd0;
      vstd_q      <= STD_PAL;
      done_q      <= 1'b0;
      dbus_addr_q <= 16'd0;
      dbus_data_q <= 8'd0;
      dbus_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      std_q       <= std_d;
      idx_q       <= idx_d;
      vstd_q      <= vstd_d;
      done_q      <= done_d;
      dbus_addr_q <= dbus_addr_d;
      dbus_data_q <= dbus_data_d;
      dbus_we_q   <= dbus_we_d;
    end
  end

  always_comb begin
    bus.req_ready         = (state_q == IDLE);
    bus.busy              = (state_q != IDLE);
    bus.host_stall        = (state_q == WRITE) || (state_q == COMMIT);
    bus.dbus_addr         = dbus_addr_q;
    bus.dbus_write_data   = dbus_data_q;
    bus.dbus_write_enable = dbus_we_q;
    bus.video_standard    = vstd_q;
    bus.done              = done_q;
  end

endmodule

// File: tb/tb_encoder_config_sequencer.sv
// Directed bench for encoder_config_sequencer: reload sequences, request/newframe overlap,
// host stall, invalid standard, mid-write reset and (with SEQ_TIMEOUT_EN) the watchdog.
module tb_encoder_config_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  encoder_config_sequencer_if bus ();

`ifdef SEQ_TIMEOUT_EN
  encoder_config_sequencer #(.NUM_ENTRIES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`else
  encoder_config_sequencer #(.NUM_ENTRIES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  // Expected table values, rows PAL/NTSC/SECAM.
  logic [7:0] exp_data [3][8] = '{
    '{8'h9A, 8'h44, 8'h60, 8'h10, 8'h02, 8'h04, 8'h04, 8'h01},
    '{8'h94, 8'h4B, 8'h6A, 8'h18, 8'h03, 8'h05, 8'h05, 8'h03},
    '{8'h9A, 8'h3A, 8'h52, 8'h10, 8'h02, 8'h06, 8'h06, 8'h05}
  };

  function automatic logic [15:0] exp_addr(input logic [1:0] std, input int i);
    logic [15:0] a;
    case (i)
      0:       a = 16'h0200 + {14'd0, std};
      1:       a = 16'h0204 + {14'd0, std};
      2:       a = 16'h0208 + {14'd0, std};
      3:       a = 16'h0009;
      4:       a = 16'h0000;
      5:       a = 16'h000C;
      6:       a = 16'h000D;
      default: a = 16'h0006;
    endcase
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the negedge where newframe (or the timeout cycle) is presented.
  task automatic expect_seq(input logic [1:0] std, input bit host_hold, input string tag);
    int stalls;
    stalls = 0;
    step();
    bus.newframe = 1'b0;
    chk($sformatf("%s first WRITE cycle no dbus write", tag), 32'(bus.dbus_write_enable), 32'd0);
    if (bus.host_stall) stalls++;
    if (host_hold) begin
      bus.host_addr         = 16'h0009;
      bus.host_write_data   = 8'h40;
      bus.host_write_enable = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("%s w%0d addr", tag, i), 32'(bus.dbus_addr), 32'(exp_addr(std, i)));
      chk($sformatf("%s w%0d data", tag, i), 32'(bus.dbus_write_data), 32'(exp_data[std][i]));
      chk($sformatf("%s w%0d we", tag, i), 32'(bus.dbus_write_enable), 32'd1);
      if (bus.host_stall) stalls++;
    end
    step();
    chk($sformatf("%s done", tag), 32'(bus.done), 32'd1);
    chk($sformatf("%s video_standard", tag), 32'(bus.video_standard), 32'(std));
    chk($sformatf("%s busy after commit", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s no write in commit", tag), 32'(bus.dbus_write_enable), 32'd0);
    if (bus.host_stall) stalls++;
    chk($sformatf("%s host_stall cycles", tag), 32'(stalls), 32'd9);
    step();
    chk($sformatf("%s done single cycle", tag), 32'(bus.done), 32'd0);
    if (host_hold) begin
      chk($sformatf("%s host addr after stall", tag), 32'(bus.dbus_addr), 32'h0009);
      chk($sformatf("%s host data after stall", tag), 32'(bus.dbus_write_data), 32'h40);
      chk($sformatf("%s host we after stall", tag), 32'(bus.dbus_write_enable), 32'd1);
      bus.host_write_enable = 1'b0;
    end else begin
      chk($sformatf("%s idle bus", tag), 32'(bus.dbus_write_enable), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                 = 1'b0;
    bus.req_valid         = 1'b0;
    bus.req_standard      = 2'd0;
    bus.newframe          = 1'b0;
    bus.host_addr         = 16'd0;
    bus.host_write_data   = 8'd0;
    bus.host_write_enable = 1'b0;
    repeat (3) step();

    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset video_standard", 32'(bus.video_standard), 32'd0);
    chk("reset dbus_addr", 32'(bus.dbus_addr), 32'd0);
    chk("reset dbus_we", 32'(bus.dbus_write_enable), 32'd0);
    chk("reset host_stall", 32'(bus.host_stall), 32'd0);
    rst_n = 1'b1;
    step();

    // NTSC reload, newframe 10 cycles after the request.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd1;
    step();
    bus.req_valid = 1'b0;
    chk("t1 busy in WAIT_FRAME", 32'(bus.busy), 32'd1);
    chk("t1 req_ready low", 32'(bus.req_ready), 32'd0);
    repeat (9) step();
    chk("t1 no write before frame", 32'(bus.dbus_write_enable), 32'd0);
    bus.newframe = 1'b1;
    expect_seq(2'd1, 1'b0, "t1");

    // SECAM request coincident with newframe: that frame start is ignored.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd2;
    bus.newframe     = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.newframe  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("t2 wait c%0d no write", c), 32'(bus.dbus_write_enable), 32'd0);
      chk($sformatf("t2 wait c%0d no stall", c), 32'(bus.host_stall), 32'd0);
      chk($sformatf("t2 wait c%0d busy", c), 32'(bus.busy), 32'd1);
    end
    bus.newframe = 1'b1;
    expect_seq(2'd2, 1'b0, "t2");

    // NTSC reload with a host write held across WRITE/COMMIT.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd1;
    step();
    bus.req_valid = 1'b0;
    repeat (3) step();
    bus.newframe = 1'b1;
    expect_seq(2'd1, 1'b1, "t3");

    // Invalid standard 3 is swallowed in IDLE.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd3;
    step();
    bus.req_valid = 1'b0;
    chk("t4 req_ready stays", 32'(bus.req_ready), 32'd1);
    chk("t4 not busy", 32'(bus.busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t4 c%0d no write", c), 32'(bus.dbus_write_enable), 32'd0);
      chk($sformatf("t4 c%0d no done", c), 32'(bus.done), 32'd0);
      chk($sformatf("t4 c%0d standard kept", c), 32'(bus.video_standard), 32'd1);
    end

    // SECAM reload aborted by reset after the 4th table write.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd2;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.newframe = 1'b1;
    step();
    bus.newframe = 1'b0;
    repeat (4) step();
    chk("t5 4th write addr", 32'(bus.dbus_addr), 32'h0009);
    chk("t5 4th write data", 32'(bus.dbus_write_data), 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5 rst dbus_we", 32'(bus.dbus_write_enable), 32'd0);
    chk("t5 rst dbus_addr", 32'(bus.dbus_addr), 32'd0);
    chk("t5 rst dbus_data", 32'(bus.dbus_write_data), 32'd0);
    chk("t5 rst video_standard PAL", 32'(bus.video_standard), 32'd0);
    chk("t5 rst busy", 32'(bus.busy), 32'd0);
    chk("t5 rst done", 32'(bus.done), 32'd0);
    chk("t5 rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("t5 rst host_stall", 32'(bus.host_stall), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd0;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.newframe = 1'b1;
    expect_seq(2'd0, 1'b0, "t5");

`ifdef SEQ_TIMEOUT_EN
    // No newframe: the watchdog fires in the 16th WAIT_FRAME cycle.
    bus.req_valid    = 1'b1;
    bus.req_standard = 2'd1;
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      chk($sformatf("t6 cycle %0d no timeout", c), 32'(bus.timeout), 32'd0);
      step();
    end
    chk("t6 timeout pulse", 32'(bus.timeout), 32'd1);
    expect_seq(2'd1, 1'b0, "t6");
    chk("t6 timeout cleared", 32'(bus.timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
